// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ISSUE, WAIT_RSP)
//   bus_owner_e : which requester owns the transaction in flight
//   MASK_*      : byte-enable patterns carried on mem_cmd_mask
package riscv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } bus_owner_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage : riscv_bus_pkg

// File: rtl/riscv_bus_arbiter_if.sv
// riscv_bus_arbiter_if
// Bundles the three channels around the arbiter:
//   iBus_*  : instruction fetch command and response (core side)
//   dBus_*  : data load/store command and response (core side)
//   mem_*   : shared memory command and response (fabric side)
// Modports:
//   slave   : the arbiter's view (takes core commands, drives memory)
//   master  : the environment's view (core plus memory model)
interface riscv_bus_arbiter_if;

    logic        iBus_cmd_valid;
    logic        iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_ready;
    logic        iBus_rsp_err;
    logic [31:0] iBus_rsp_instr;

    logic        dBus_cmd_valid;
    logic        dBus_cmd_ready;
    logic [31:0] dBus_cmd_payload_addr;
    logic [31:0] dBus_cmd_payload_data;
    logic [3:0]  dBus_cmd_payload_size;
    logic        dBus_cmd_payload_wr;
    logic        dBus_rsp_valid;
    logic [31:0] dBus_rsp_data;
    logic        dBus_rsp_error;

    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_cmd_data;
    logic [3:0]  mem_cmd_mask;
    logic        mem_cmd_wr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;

    modport slave (
        input  iBus_cmd_valid, iBus_cmd_payload_pc,
        output iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_instr,
        input  dBus_cmd_valid, dBus_cmd_payload_addr, dBus_cmd_payload_data,
        input  dBus_cmd_payload_size, dBus_cmd_payload_wr,
        output dBus_cmd_ready, dBus_rsp_valid, dBus_rsp_data, dBus_rsp_error,
        output mem_cmd_valid, mem_cmd_addr, mem_cmd_data, mem_cmd_mask, mem_cmd_wr,
        input  mem_cmd_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
    );

    modport master (
        output iBus_cmd_valid, iBus_cmd_payload_pc,
        input  iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, iBus_rsp_instr,
        output dBus_cmd_valid, dBus_cmd_payload_addr, dBus_cmd_payload_data,
        output dBus_cmd_payload_size, dBus_cmd_payload_wr,
        input  dBus_cmd_ready, dBus_rsp_valid, dBus_rsp_data, dBus_rsp_error,
        input  mem_cmd_valid, mem_cmd_addr, mem_cmd_data, mem_cmd_mask, mem_cmd_wr,
        output mem_cmd_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
    );

endinterface : riscv_bus_arbiter_if

// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter
// Shares one memory command/response channel between the instruction bus
// and the data bus. One transaction is outstanding at a time: a command is
// granted in IDLE, presented to memory from a register in ISSUE, and its
// response is routed back to the owner from WAIT_RSP as a one-cycle pulse.
// dBus wins arbitration unless iBus has lost MAX_WAIT times in a row. A
// response that never arrives is replaced by an error after TIMEOUT cycles.
// Ports:
//   clk   : clock, rising edge
//   rstf  : asynchronous active-low reset
//   bus   : iBus / dBus / mem channels (riscv_bus_arbiter_if.slave)
//   busy  : high whenever a transaction is in flight (state != IDLE)
module riscv_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int MAX_WAIT = 4,     // 1..15
    parameter int TIMEOUT  = 255    // 0 disables the response timeout
) (
    input  logic                       clk,
    input  logic                       rstf,
    riscv_bus_arbiter_if.slave         bus,
    output logic                       busy
);

    localparam int              TO_W         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST      = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [3:0]      STARVE_LIMIT = 4'(MAX_WAIT);
    localparam logic [3:0]      STARVE_MAX   = 4'hF;

    arb_state_e      state_q, state_d;
    bus_owner_e      owner_q, owner_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic            mem_cmd_valid_q, mem_cmd_valid_d;
    logic [31:0]     mem_cmd_addr_q, mem_cmd_addr_d;
    logic [31:0]     mem_cmd_data_q, mem_cmd_data_d;
    logic [3:0]      mem_cmd_mask_q, mem_cmd_mask_d;
    logic            mem_cmd_wr_q, mem_cmd_wr_d;

    logic            i_rsp_valid_q, i_rsp_valid_d;
    logic            i_rsp_err_q, i_rsp_err_d;
    logic [31:0]     i_rsp_instr_q, i_rsp_instr_d;
    logic            d_rsp_valid_q, d_rsp_valid_d;
    logic            d_rsp_err_q, d_rsp_err_d;
    logic [31:0]     d_rsp_data_q, d_rsp_data_d;

    logic            grant_i, grant_d;
    logic            rsp_fire;
    logic            rsp_err;
    logic [31:0]     rsp_data;

    // Arbitration: only meaningful in IDLE. iBus takes the grant when dBus is
    // absent or when iBus has already been passed over MAX_WAIT times.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (bus.iBus_cmd_valid &&
                (!bus.dBus_cmd_valid || (starve_cnt_q >= STARVE_LIMIT))) begin
                grant_i = 1'b1;
            end else if (bus.dBus_cmd_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    // Response selection in WAIT_RSP: a real memory response beats the
    // timeout when both happen in the same cycle.
    always_comb begin
        rsp_fire = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = 32'h0;
        if (state_q == WAIT_RSP) begin
            if (bus.mem_rsp_valid) begin
                rsp_fire = 1'b1;
                rsp_err  = bus.mem_rsp_err;
                rsp_data = bus.mem_rsp_data;
            end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
                rsp_fire = 1'b1;
                rsp_err  = 1'b1;
                rsp_data = 32'h0;
            end
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        starve_cnt_d    = starve_cnt_q;
        to_cnt_d        = to_cnt_q;
        mem_cmd_valid_d = mem_cmd_valid_q;
        mem_cmd_addr_d  = mem_cmd_addr_q;
        mem_cmd_data_d  = mem_cmd_data_q;
        mem_cmd_mask_d  = mem_cmd_mask_q;
        mem_cmd_wr_d    = mem_cmd_wr_q;
        // Response valids are pulses; data/err hold until the next response.
        i_rsp_valid_d   = 1'b0;
        i_rsp_err_d     = i_rsp_err_q;
        i_rsp_instr_d   = i_rsp_instr_q;
        d_rsp_valid_d   = 1'b0;
        d_rsp_err_d     = d_rsp_err_q;
        d_rsp_data_d    = d_rsp_data_q;

        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    owner_d         = OWNER_I;
                    mem_cmd_valid_d = 1'b1;
                    mem_cmd_addr_d  = bus.iBus_cmd_payload_pc;
                    mem_cmd_data_d  = 32'h0;
                    mem_cmd_mask_d  = MASK_WORD;
                    mem_cmd_wr_d    = 1'b0;
                    starve_cnt_d    = 4'h0;
                    state_d         = ISSUE;
                end else if (grant_d) begin
                    owner_d         = OWNER_D;
                    mem_cmd_valid_d = 1'b1;
                    mem_cmd_addr_d  = bus.dBus_cmd_payload_addr;
                    mem_cmd_data_d  = bus.dBus_cmd_payload_data;
                    mem_cmd_mask_d  = bus.dBus_cmd_payload_size;
                    mem_cmd_wr_d    = bus.dBus_cmd_payload_wr;
                    // iBus only counts as starved if it actually asked.
                    if (bus.iBus_cmd_valid && (starve_cnt_q != STARVE_MAX)) begin
                        starve_cnt_d = starve_cnt_q + 4'h1;
                    end
                    state_d         = ISSUE;
                end
            end

            ISSUE: begin
                // Payload registers hold; memory may stall indefinitely here.
                if (bus.mem_cmd_ready) begin
                    mem_cmd_valid_d = 1'b0;
                    to_cnt_d        = '0;
                    state_d         = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (rsp_fire) begin
                    if (owner_q == OWNER_I) begin
                        i_rsp_valid_d = 1'b1;
                        i_rsp_err_d   = rsp_err;
                        i_rsp_instr_d = rsp_data;
                    end else begin
                        d_rsp_valid_d = 1'b1;
                        d_rsp_err_d   = rsp_err;
                        d_rsp_data_d  = rsp_data;
                    end
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q         <= IDLE;
            owner_q         <= OWNER_I;
            starve_cnt_q    <= 4'h0;
            to_cnt_q        <= '0;
            mem_cmd_valid_q <= 1'b0;
            mem_cmd_addr_q  <= 32'h0;
            mem_cmd_data_q  <= 32'h0;
            mem_cmd_mask_q  <= 4'h0;
            mem_cmd_wr_q    <= 1'b0;
            i_rsp_valid_q   <= 1'b0;
            i_rsp_err_q     <= 1'b0;
            i_rsp_instr_q   <= 32'h0;
            d_rsp_valid_q   <= 1'b0;
            d_rsp_err_q     <= 1'b0;
            d_rsp_data_q    <= 32'h0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            starve_cnt_q    <= starve_cnt_d;
            to_cnt_q        <= to_cnt_d;
            mem_cmd_valid_q <= mem_cmd_valid_d;
            mem_cmd_addr_q  <= mem_cmd_addr_d;
            mem_cmd_data_q  <= mem_cmd_data_d;
            mem_cmd_mask_q  <= mem_cmd_mask_d;
            mem_cmd_wr_q    <= mem_cmd_wr_d;
            i_rsp_valid_q   <= i_rsp_valid_d;
            i_rsp_err_q     <= i_rsp_err_d;
            i_rsp_instr_q   <= i_rsp_instr_d;
            d_rsp_valid_q   <= d_rsp_valid_d;
            d_rsp_err_q     <= d_rsp_err_d;
            d_rsp_data_q    <= d_rsp_data_d;
        end
    end

    assign bus.iBus_cmd_ready = grant_i;
    assign bus.dBus_cmd_ready = grant_d;
    assign bus.iBus_rsp_ready = i_rsp_valid_q;
    assign bus.iBus_rsp_err   = i_rsp_err_q;
    assign bus.iBus_rsp_instr = i_rsp_instr_q;
    assign bus.dBus_rsp_valid = d_rsp_valid_q;
    assign bus.dBus_rsp_error = d_rsp_err_q;
    assign bus.dBus_rsp_data  = d_rsp_data_q;
    assign bus.mem_cmd_valid  = mem_cmd_valid_q;
    assign bus.mem_cmd_addr   = mem_cmd_addr_q;
    assign bus.mem_cmd_data   = mem_cmd_data_q;
    assign bus.mem_cmd_mask   = mem_cmd_mask_q;
    assign bus.mem_cmd_wr     = mem_cmd_wr_q;
    assign busy               = (state_q != IDLE);

endmodule : riscv_bus_arbiter

// File: doc/riscv_bus_arbiter.md
# riscv_bus_arbiter

Single-port memory arbiter that shares one memory command/response channel between the core's instruction bus (iBus) and data bus (dBus). It sits between the `riscv` core and the memory model/SoC fabric, registering each accepted command and routing the matching response back to its owner. It enforces one outstanding transaction at a time, data-priority arbitration with an instruction-starvation guard, and a response timeout that returns an error to the owner.

## Interface
Parameters:
- `MAX_WAIT`, default 4: consecutive lost arbitrations after which iBus wins over dBus; range 1..15.
- `TIMEOUT`, default 255: WAIT_RSP cycles before a synthetic error response; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rstf`  in  1  reset, asynchronous and active-low.
- `iBus_cmd_valid`  in  1  fetch request.
- `iBus_cmd_ready`  out  1  fetch accepted this cycle.
- `iBus_cmd_payload_pc`  in  32  fetch address.
- `iBus_rsp_ready`  out  1  one-cycle fetch response pulse.
- `iBus_rsp_err`  out  1  fetch error, valid with `iBus_rsp_ready`.
- `iBus_rsp_instr`  out  32  fetched word.
- `dBus_cmd_valid`  in  1  data request.
- `dBus_cmd_ready`  out  1  data request accepted this cycle.
- `dBus_cmd_payload_addr`  in  32  data address.
- `dBus_cmd_payload_data`  in  32  store data.
- `dBus_cmd_payload_size`  in  4  byte mask (0001/0011/1111).
- `dBus_cmd_payload_wr`  in  1  1 = write, 0 = read.
- `dBus_rsp_valid`  out  1  one-cycle data response pulse.
- `dBus_rsp_data`  out  32  load data.
- `dBus_rsp_error`  out  1  data error.
- `mem_cmd_valid`  out  1  registered command to memory.
- `mem_cmd_ready`  in  1  memory accepts command.
- `mem_cmd_addr`  out  32  command address.
- `mem_cmd_data`  out  32  write data.
- `mem_cmd_mask`  out  4  byte mask.
- `mem_cmd_wr`  out  1  write flag.
- `mem_rsp_valid`  in  1  memory response; one per command, writes included.
- `mem_rsp_data`  in  32  read data.
- `mem_rsp_err`  in  1  memory error.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE: arbitrate among the valid requesters.
  - Winner is dBus unless `starve_cnt >= MAX_WAIT`, in which case iBus wins.
  - Winner's `*_cmd_ready` = 1 combinationally; the loser's ready = 0.
  - On grant: latch payload into the `mem_cmd_*` registers and latch `owner`; go to ISSUE.
  - iBus command: mask = 4'b1111, wr = 0, data = 0.
- `starve_cnt` (4-bit):
  - Increments, saturating at 15, in IDLE when `iBus_cmd_valid` is high and dBus wins.
  - Clears when iBus is granted.
  - Holds otherwise.
- ISSUE: `mem_cmd_valid` = 1 with stable payload until `mem_cmd_ready`, then go to WAIT_RSP. There is no timeout in ISSUE.
- WAIT_RSP:
  - `to_cnt` increments each cycle.
  - On `mem_rsp_valid`: register data/err into the owner's response outputs, pulse the owner's valid for one cycle, go to IDLE.
  - Else, if TIMEOUT != 0 and `to_cnt == TIMEOUT-1`: pulse owner valid with err = 1 and data = 0, go to IDLE.
  - `to_cnt` clears on entry to WAIT_RSP.
- Stray `mem_rsp_valid` outside WAIT_RSP (including a late response after a timeout) is dropped; response outputs are unchanged.
- The non-owner response valid is never asserted.

## Timing
- Reset: state = IDLE, `mem_cmd_valid` = 0, `mem_cmd_*` = 0, all response valids/errs = 0, response data = 0, `starve_cnt` = 0, `to_cnt` = 0, `busy` = 0.
- Latency, with grant in cycle T:
  - `mem_cmd_valid` is high from T+1.
  - If ready at T+1, state is WAIT_RSP at T+2.
  - Earliest `mem_rsp_valid` is at T+2.
  - Requester response pulse at T+3, with state back in IDLE at T+3.
  - Next grant possible at T+3, giving a 3-cycle minimum per transaction.
- Response outputs are registered; the valid pulse is exactly one cycle.
- Payload inputs are sampled only on the grant cycle; later requester changes are ignored.
- `rstf` low mid-transaction: immediate return to IDLE and all outputs to reset values; the in-flight response is lost.
- Counter widths: `to_cnt` is `$clog2(TIMEOUT+1)` bits, min 1; `starve_cnt` is 4 bits.

## Structure
- Package `riscv_bus_pkg`:
  - `arb_state_e` (IDLE/ISSUE/WAIT_RSP).
  - `bus_owner_e` (OWNER_I/OWNER_D).
  - `MASK_BYTE` = 4'b0001, `MASK_HALF` = 4'b0011, `MASK_WORD` = 4'b1111.
- Single module; no sub-module. The arbitration function is small enough to stay inline.

## Test plan
- Lone fetch: iBus pc = 0x100, memory ready immediately, rsp 0x00000013 two cycles later -> `iBus_rsp_ready` pulses at T+3 with instr 0x00000013, err = 0; `dBus_rsp_valid` stays 0.
- Store: dBus addr = 0x2000, data = 0xDEADBEEF, size = 0001, wr = 1 -> `mem_cmd` carries the same addr/data/mask/wr=1 from T+1 until ready; the write ack produces a single `dBus_rsp_valid` pulse.
- Contention, MAX_WAIT = 4: both requesters valid every cycle -> dBus granted 4 times, 5th grant to iBus, `starve_cnt` back to 0, pattern repeats.
- Backpressure: `mem_cmd_ready` held low 10 cycles -> `mem_cmd_valid` and payload stable for all 10 cycles, no new requester ready, `busy` = 1.
- Timeout, TIMEOUT = 8: no memory response -> owner gets err = 1, data = 0 exactly 8 cycles after entering WAIT_RSP; a late `mem_rsp_valid` is dropped.
- Reset mid WAIT_RSP: `rstf` low for 1 cycle -> all outputs at reset values asynchronously; a new fetch completes normally afterward.
